hhmm_set_ctrl: RTL and testbench

Time-setting controller for the HH:MM clock datapath. Sits between the front-panel buttons, the minute timebase tick and the minute/hour counter chain. In run mode it forwards the timebase tick to the minute counters. In set mode it suppresses the tick and generates single-step and auto-repeat pulses to the selected field, with blink enables for the display.

---
 rtl/hhmm_set_ctrl.sv | 166 ++++++++++++++++
 tb/tb_hhmm_set_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/hhmm_set_ctrl.sv
// Time-setting controller for the HH:MM clock: forwards the minute tick in run mode,
// and in set mode generates single-step / auto-repeat pulses plus blink enables.
module hhmm_set_ctrl #(
    parameter int unsigned HOLD_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD = 10_000_000,
    parameter int unsigned BLINK_HALF    = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic mode_btn,
    input  logic adj_btn,
    input  logic down_sw,
    output logic min_pulse,
    output logic hour_pulse,
    output logic dec,
    output logic blink_min,
    output logic blink_hour,
    output logic div_clear
);

    localparam int unsigned RPT_MAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW      = $clog2(RPT_MAX + 1);
    localparam int unsigned BW      = $clog2(BLINK_HALF + 1);

    localparam logic [RW-1:0] HOLD_LOAD  = RW'(HOLD_DELAY - 1);
    localparam logic [RW-1:0] RPT_LOAD   = RW'(REPEAT_PERIOD - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } state_e;

    logic [1:0]    mode_sync_q, adj_sync_q, down_sync_q;
    logic          mode_prev_q, adj_prev_q;
    state_e        state_q, state_d;
    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic          rpt_act_q, rpt_act_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;
    logic          min_pulse_q, min_pulse_d;
    logic          hour_pulse_q, hour_pulse_d;
    logic          dec_q, dec_d;
    logic          blink_min_q, blink_min_d;
    logic          blink_hour_q, blink_hour_d;
    logic          div_clear_q, div_clear_d;

    logic mode_edge, adj_edge, adj_held, in_set, step;

    assign mode_edge = mode_sync_q[1] & ~mode_prev_q;
    assign adj_edge  = adj_sync_q[1] & ~adj_prev_q;
    assign adj_held  = adj_sync_q[1];
    assign in_set    = (state_q != RUN);

    // Next-state and output decode; a mode edge always pre-empts any step.
    always_comb begin
        state_d      = state_q;
        rpt_cnt_d    = rpt_cnt_q;
        rpt_act_d    = rpt_act_q;
        blink_cnt_d  = blink_cnt_q;
        blink_d      = blink_q;
        step         = 1'b0;
        min_pulse_d  = 1'b0;
        hour_pulse_d = 1'b0;
        div_clear_d  = 1'b0;

        if (mode_edge) begin
            unique case (state_q)
                RUN:      state_d = SET_HOUR;
                SET_HOUR: state_d = SET_MIN;
                SET_MIN: begin
                    state_d     = RUN;
                    div_clear_d = 1'b1;
                end
                default:  state_d = RUN;
            endcase
            rpt_cnt_d = '0;
            rpt_act_d = 1'b0;
        end else if (in_set) begin
            if (adj_edge) begin
                step      = 1'b1;
                rpt_cnt_d = HOLD_LOAD;
                rpt_act_d = 1'b1;
            end else if (!adj_held) begin
                rpt_cnt_d = '0;
                rpt_act_d = 1'b0;
            end else if (rpt_act_q) begin
                if (rpt_cnt_q == '0) begin
                    step      = 1'b1;
                    rpt_cnt_d = RPT_LOAD;
                end else begin
                    rpt_cnt_d = rpt_cnt_q - RW'(1);
                end
            end
        end

        if (state_q == RUN) begin
            min_pulse_d = tick;
        end else if (state_q == SET_MIN) begin
            min_pulse_d = step;
        end
        hour_pulse_d = step & (state_q == SET_HOUR);
        dec_d        = (state_d != RUN) & down_sync_q[1];

        // Blink phase restarts visible on every state change.
        if (state_d != state_q) begin
            blink_cnt_d = '0;
            blink_d     = 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
        end
        blink_hour_d = blink_d & (state_d == SET_HOUR);
        blink_min_d  = blink_d & (state_d == SET_MIN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_sync_q  <= '0;
            adj_sync_q   <= '0;
            down_sync_q  <= '0;
            mode_prev_q  <= 1'b0;
            adj_prev_q   <= 1'b0;
            state_q      <= RUN;
            rpt_cnt_q    <= '0;
            rpt_act_q    <= 1'b0;
            blink_cnt_q  <= '0;
            blink_q      <= 1'b0;
            min_pulse_q  <= 1'b0;
            hour_pulse_q <= 1'b0;
            dec_q        <= 1'b0;
            blink_min_q  <= 1'b0;
            blink_hour_q <= 1'b0;
            div_clear_q  <= 1'b0;
        end else begin
            mode_sync_q  <= {mode_sync_q[0], mode_btn};
            adj_sync_q   <= {adj_sync_q[0], adj_btn};
            down_sync_q  <= {down_sync_q[0], down_sw};
            mode_prev_q  <= mode_sync_q[1];
            adj_prev_q   <= adj_sync_q[1];
            state_q      <= state_d;
            rpt_cnt_q    <= rpt_cnt_d;
            rpt_act_q    <= rpt_act_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_q      <= blink_d;
            min_pulse_q  <= min_pulse_d;
            hour_pulse_q <= hour_pulse_d;
            dec_q        <= dec_d;
            blink_min_q  <= blink_min_d;
            blink_hour_q <= blink_hour_d;
            div_clear_q  <= div_clear_d;
        end
    end

    assign min_pulse  = min_pulse_q;
    assign hour_pulse = hour_pulse_q;
    assign dec        = dec_q;
    assign blink_min  = blink_min_q;
    assign blink_hour = blink_hour_q;
    assign div_clear  = div_clear_q;

endmodule

// File: tb/tb_hhmm_set_ctrl.sv
// Directed bench for hhmm_set_ctrl: expected pulse events are queued as stimulus is
// driven and matched against every observed pulse; levels are checked in place.
module tb_hhmm_set_ctrl;

    localparam int unsigned HD = 8;
    localparam int unsigned RP = 4;
    localparam int unsigned BH = 5;

    localparam int K_MIN  = 0;
    localparam int K_HOUR = 1;
    localparam int K_DIV  = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tick = 1'b0;
    logic mode_btn = 1'b0;
    logic adj_btn = 1'b0;
    logic down_sw = 1'b0;
    logic min_pulse, hour_pulse, dec, blink_min, blink_hour, div_clear;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int cyc;
        int kind;
    } ev_t;
    ev_t exp_q[$];

    hhmm_set_ctrl #(
        .HOLD_DELAY   (HD),
        .REPEAT_PERIOD(RP),
        .BLINK_HALF   (BH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .mode_btn  (mode_btn),
        .adj_btn   (adj_btn),
        .down_sw   (down_sw),
        .min_pulse (min_pulse),
        .hour_pulse(hour_pulse),
        .dec       (dec),
        .blink_min (blink_min),
        .blink_hour(blink_hour),
        .div_clear (div_clear)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_event(input int kind);
        ev_t e;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_pulse observed=kind%0d@cyc%0d expected=none", kind, cyc);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pulse_kind", kind, e.kind);
            check("pulse_cycle", cyc, e.cyc);
        end
    endtask

    // Every observed pulse cycle must match the head of the expected queue.
    always @(negedge clk) begin
        if (min_pulse === 1'b1)  check_event(K_MIN);
        if (hour_pulse === 1'b1) check_event(K_HOUR);
        if (div_clear === 1'b1)  check_event(K_DIV);
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic press_mode(input bit exp_div, output int c);
        mode_btn = 1'b1;
        c = cyc;
        if (exp_div) exp_q.push_back('{c + 3, K_DIV});
        repeat (3) @(negedge clk);
        mode_btn = 1'b0;
    endtask

    task automatic pulse_tick(input bit expect_fwd);
        tick = 1'b1;
        if (expect_fwd) exp_q.push_back('{cyc + 1, K_MIN});
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_min_pulse"}, min_pulse, 0);
        check({tag, "_hour_pulse"}, hour_pulse, 0);
        check({tag, "_dec"}, dec, 0);
        check({tag, "_blink_min"}, blink_min, 0);
        check({tag, "_blink_hour"}, blink_hour, 0);
        check({tag, "_div_clear"}, div_clear, 0);
    endtask

    initial begin
        int c;
        int s;

        #3 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Run mode: ticks forwarded one cycle later.
        for (int i = 0; i < 3; i++) begin
            pulse_tick(1'b1);
            check("run_dec", dec, 0);
            repeat (9) @(negedge clk);
        end
        check("run_queue_drained", exp_q.size(), 0);

        // SET_HOUR: blink phase, then held adjust with auto-repeat.
        press_mode(1'b0, c);
        s = c + 3;
        wait_until(s + 4);
        check("sethour_blink_off", blink_hour, 0);
        wait_until(s + 5);
        check("sethour_blink_on", blink_hour, 1);
        check("sethour_blink_min", blink_min, 0);
        adj_btn = 1'b1;
        c = cyc;
        exp_q.push_back('{c + 3, K_HOUR});
        exp_q.push_back('{c + 3 + 8, K_HOUR});
        exp_q.push_back('{c + 3 + 12, K_HOUR});
        exp_q.push_back('{c + 3 + 16, K_HOUR});
        exp_q.push_back('{c + 3 + 20, K_HOUR});
        wait_until(c + 22);
        adj_btn = 1'b0;
        check("sethour_dec_up", dec, 0);
        repeat (10) @(negedge clk);
        check("repeat_queue_drained", exp_q.size(), 0);

        // SET_MIN: blink timing, tick discarded, single decrement step.
        press_mode(1'b0, c);
        s = c + 3;
        wait_until(s + 4);
        check("setmin_blink_off", blink_min, 0);
        check("setmin_blink_hour", blink_hour, 0);
        wait_until(s + 5);
        check("setmin_blink_on", blink_min, 1);
        wait_until(s + 10);
        check("setmin_blink_off2", blink_min, 0);
        pulse_tick(1'b0);
        down_sw = 1'b1;
        repeat (4) @(negedge clk);
        check("setmin_dec_down", dec, 1);
        adj_btn = 1'b1;
        c = cyc;
        exp_q.push_back('{c + 3, K_MIN});
        repeat (3) @(negedge clk);
        adj_btn = 1'b0;
        repeat (15) @(negedge clk);
        check("setmin_queue_drained", exp_q.size(), 0);

        // Back to RUN: div_clear on first RUN cycle, dec forced low.
        press_mode(1'b1, c);
        check("run_dec_forced", dec, 0);
        check("run_blink_min", blink_min, 0);
        down_sw = 1'b0;
        repeat (3) @(negedge clk);
        pulse_tick(1'b1);
        repeat (5) @(negedge clk);
        check("rerun_queue_drained", exp_q.size(), 0);

        // Mode and adjust rising together: mode wins, no step, no repeat afterwards.
        press_mode(1'b0, c);
        repeat (3) @(negedge clk);
        mode_btn = 1'b1;
        adj_btn  = 1'b1;
        c = cyc;
        repeat (3) @(negedge clk);
        mode_btn = 1'b0;
        s = c + 3;
        wait_until(s + 5);
        check("collide_blink_min", blink_min, 1);
        check("collide_blink_hour", blink_hour, 0);
        wait_until(c + 20);
        adj_btn = 1'b0;
        repeat (5) @(negedge clk);
        check("collide_queue_drained", exp_q.size(), 0);

        // Reset in SET_HOUR with adjust held.
        press_mode(1'b1, c);
        repeat (3) @(negedge clk);
        press_mode(1'b0, c);
        repeat (3) @(negedge clk);
        adj_btn = 1'b1;
        c = cyc;
        exp_q.push_back('{c + 3, K_HOUR});
        wait_until(c + 6);
        reset = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        adj_btn = 1'b0;
        repeat (15) @(negedge clk);
        check("postreset_blink_hour", blink_hour, 0);
        check("postreset_dec", dec, 0);
        pulse_tick(1'b1);
        repeat (4) @(negedge clk);
        check("final_queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
